// File: rtl/frame_capture_ctrl_pkg.sv
// Shared types and width helpers for the camera frame capture controller.
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  // Pixel counter must hold up to WIDTH+1 (the saturation value).
  function automatic int calc_pix_w(input int width);
    return $clog2(width + 2);
  endfunction

  // Internal line counter must hold up to HEIGHT+1 (the saturation value).
  function automatic int calc_line_w(input int height);
    return $clog2(height + 2);
  endfunction

  localparam int PIX_W  = calc_pix_w(640);
  localparam int LINE_W = calc_line_w(480);

endpackage

// File: rtl/frame_capture_ctrl_sync_edge_det.sv
// Two-register input stage giving a registered level plus rise/fall events.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic d_q;

  // First register captures the pin, second delays it for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      d_q   <= 1'b0;
    end else begin
      level <= din;
      d_q   <= level;
    end
  end

  assign rise = level & ~d_q;
  assign fall = ~level & d_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms on request, aligns to VSYNC, gates pixel
// writes, validates frame geometry and hands frames over a ping-pong pair.
module frame_capture_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  parameter int DROP_CNT_W        = 8
) (
  input  logic                                   PCLK,
  input  logic                                   RST_N,
  input  logic                                   VSYNC,
  input  logic                                   HREF,
  input  logic                                   start,
  input  logic                                   continuous,
  input  logic                                   stop,
  input  logic                                   buf_release,
  output logic                                   capture_en,
  output logic                                   wr_buf,
  output logic                                   ready_valid,
  output logic                                   ready_buf,
  output logic                                   frame_done,
  output logic                                   frame_err,
  output logic [DROP_CNT_W-1:0]                  dropped_cnt,
  output logic [$clog2(RESOLUTION_HEIGHT+1)-1:0] line_cnt,
  output logic                                   busy
);

  localparam int CNT_PIX_W  = calc_pix_w(RESOLUTION_WIDTH);
  localparam int CNT_LINE_W = calc_line_w(RESOLUTION_HEIGHT);
  localparam int OUT_LINE_W = $clog2(RESOLUTION_HEIGHT + 1);

  localparam logic [CNT_PIX_W-1:0]  PIX_FULL  = CNT_PIX_W'(RESOLUTION_WIDTH);
  localparam logic [CNT_PIX_W-1:0]  PIX_SAT   = CNT_PIX_W'(RESOLUTION_WIDTH + 1);
  localparam logic [CNT_LINE_W-1:0] LINE_FULL = CNT_LINE_W'(RESOLUTION_HEIGHT);
  localparam logic [CNT_LINE_W-1:0] LINE_SAT  = CNT_LINE_W'(RESOLUTION_HEIGHT + 1);

  cap_state_t            state;
  logic [CNT_PIX_W-1:0]  pix_cnt;
  logic [CNT_LINE_W-1:0] line_cnt_q;
  logic                  line_err;
  logic                  stop_pending;

  logic s_vsync, vsync_rise, vsync_fall;
  logic s_href, href_rise_unused, href_fall;
  logic good_frame;

  sync_edge_det u_vsync_det (
    .clk   (PCLK),
    .rst_n (RST_N),
    .din   (VSYNC),
    .level (s_vsync),
    .rise  (vsync_rise),
    .fall  (vsync_fall)
  );

  sync_edge_det u_href_det (
    .clk   (PCLK),
    .rst_n (RST_N),
    .din   (HREF),
    .level (s_href),
    .rise  (href_rise_unused),
    .fall  (href_fall)
  );

  assign good_frame = ~line_err & (line_cnt_q == LINE_FULL) & ~s_href;
  assign capture_en = (state == CAPTURE) & s_href;
  assign busy       = (state != IDLE);
  assign line_cnt   = line_cnt_q[OUT_LINE_W-1:0];

  // Capture sequencer with geometry checks and ping-pong buffer handoff.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      line_cnt_q   <= '0;
      line_err     <= 1'b0;
      stop_pending <= 1'b0;
      wr_buf       <= 1'b0;
      ready_valid  <= 1'b0;
      ready_buf    <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      dropped_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (buf_release && ready_valid) begin
        ready_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (start) begin
            state <= ARM;
          end
        end
        ARM: begin
          if (stop) begin
            state <= IDLE;
          end else if (vsync_fall) begin
            state      <= CAPTURE;
            pix_cnt    <= '0;
            line_cnt_q <= '0;
            line_err   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (stop) begin
            stop_pending <= 1'b1;
          end
          if (href_fall) begin
            if (pix_cnt != PIX_FULL) begin
              line_err <= 1'b1;
            end
            if (line_cnt_q >= LINE_FULL) begin
              line_err <= 1'b1;
            end
            if (line_cnt_q != LINE_SAT) begin
              line_cnt_q <= line_cnt_q + 1'b1;
            end
            pix_cnt <= '0;
          end else if (s_href && (pix_cnt != PIX_SAT)) begin
            pix_cnt <= pix_cnt + 1'b1;
          end
          if (vsync_rise) begin
            stop_pending <= 1'b0;
            state        <= (continuous && !stop_pending && !stop) ? ARM : IDLE;
            if (!good_frame) begin
              frame_err <= 1'b1;
            end else if (!ready_valid || buf_release) begin
              frame_done  <= 1'b1;
              ready_buf   <= wr_buf;
              ready_valid <= 1'b1;
              wr_buf      <= ~wr_buf;
            end else if (dropped_cnt != '1) begin
              dropped_cnt <= dropped_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed testbench for frame_capture_ctrl with a small 8x4 frame geometry.
module tb_frame_capture_ctrl;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int DW  = 8;
  localparam int LCW = $clog2(H + 1);

  logic          PCLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          VSYNC = 1'b1;
  logic          HREF = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          stop = 1'b0;
  logic          buf_release = 1'b0;
  logic          capture_en;
  logic          wr_buf;
  logic          ready_valid;
  logic          ready_buf;
  logic          frame_done;
  logic          frame_err;
  logic [DW-1:0] dropped_cnt;
  logic [LCW-1:0] line_cnt;
  logic          busy;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cap_seen  = 0;
  int done_seen = 0;
  int err_seen  = 0;

  frame_capture_ctrl #(
    .RESOLUTION_WIDTH  (W),
    .RESOLUTION_HEIGHT (H),
    .DROP_CNT_W        (DW)
  ) dut (
    .PCLK        (PCLK),
    .RST_N       (RST_N),
    .VSYNC       (VSYNC),
    .HREF        (HREF),
    .start       (start),
    .continuous  (continuous),
    .stop        (stop),
    .buf_release (buf_release),
    .capture_en  (capture_en),
    .wr_buf      (wr_buf),
    .ready_valid (ready_valid),
    .ready_buf   (ready_buf),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .dropped_cnt (dropped_cnt),
    .line_cnt    (line_cnt),
    .busy        (busy)
  );

  // Free-running pixel clock.
  always #5 PCLK = ~PCLK;

  // Tally write enables and result pulses away from the active edge.
  always @(negedge PCLK) begin
    if (capture_en === 1'b1) cap_seen = cap_seen + 1;
    if (frame_done === 1'b1) done_seen = done_seen + 1;
    if (frame_err === 1'b1) err_seen = err_seen + 1;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    VSYNC = 1'b1;
    HREF = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    buf_release = 1'b0;
    continuous = 1'b0;
    step(2);
    RST_N = 1'b1;
    step(2);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
  endtask

  task automatic pulse_release();
    buf_release = 1'b1;
    step(1);
    buf_release = 1'b0;
    step(1);
  endtask

  task automatic send_line(input int len);
    HREF = 1'b1;
    step(len);
    HREF = 1'b0;
    step(3);
  endtask

  task automatic frame_open();
    VSYNC = 1'b0;
    step(3);
  endtask

  // Leaves the caller on the cycle where a result pulse is expected.
  task automatic frame_close();
    VSYNC = 1'b1;
    step(2);
  endtask

  task automatic send_frame(input int bad_line, input int bad_len);
    frame_open();
    for (int l = 0; l < H; l++) begin
      send_line((l == bad_line) ? bad_len : W);
    end
    frame_close();
  endtask

  task automatic test_reset();
    int d0, e0;
    RST_N = 1'b0;
    step(3);
    vec_cnt++; if (capture_en !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_capture_en: got %b expected 0", capture_en); end
    vec_cnt++; if (wr_buf !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_wr_buf: got %b expected 0", wr_buf); end
    vec_cnt++; if (ready_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_ready_valid: got %b expected 0", ready_valid); end
    vec_cnt++; if (ready_buf !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_ready_buf: got %b expected 0", ready_buf); end
    vec_cnt++; if ({frame_done, frame_err} !== 2'b00) begin miss_cnt++; $display("[TB] FAIL rst_pulses: got %b expected 00", {frame_done, frame_err}); end
    vec_cnt++; if (dropped_cnt !== '0) begin miss_cnt++; $display("[TB] FAIL rst_dropped: got %0d expected 0", dropped_cnt); end
    vec_cnt++; if (line_cnt !== '0) begin miss_cnt++; $display("[TB] FAIL rst_line_cnt: got %0d expected 0", line_cnt); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    RST_N = 1'b1;
    step(2);
    // Reset in the middle of a capture after two lines.
    pulse_start();
    frame_open();
    send_line(W);
    send_line(W);
    vec_cnt++; if (line_cnt !== LCW'(2)) begin miss_cnt++; $display("[TB] FAIL midrst_pre_lines: got %0d expected 2", line_cnt); end
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("[TB] FAIL midrst_pre_busy: got %b expected 1", busy); end
    HREF = 1'b1;
    step(3);
    RST_N = 1'b0;
    #2;
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    vec_cnt++; if (line_cnt !== '0) begin miss_cnt++; $display("[TB] FAIL midrst_line_cnt: got %0d expected 0", line_cnt); end
    vec_cnt++; if (capture_en !== 1'b0) begin miss_cnt++; $display("[TB] FAIL midrst_capture_en: got %b expected 0", capture_en); end
    d0 = done_seen;
    e0 = err_seen;
    step(2);
    RST_N = 1'b1;
    step(4);
    HREF = 1'b0;
    step(3);
    send_line(W);
    VSYNC = 1'b1;
    step(6);
    vec_cnt++; if (done_seen - d0 != 0) begin miss_cnt++; $display("[TB] FAIL midrst_done_count: got %0d expected 0", done_seen - d0); end
    vec_cnt++; if (err_seen - e0 != 0) begin miss_cnt++; $display("[TB] FAIL midrst_err_count: got %0d expected 0", err_seen - e0); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL midrst_post_busy: got %b expected 0", busy); end
  endtask

  task automatic test_good_frame();
    int d0, e0, c0;
    do_reset();
    d0 = done_seen; e0 = err_seen; c0 = cap_seen;
    pulse_start();
    send_frame(-1, 0);
    vec_cnt++; if (frame_done !== 1'b1) begin miss_cnt++; $display("[TB] FAIL good_done_pulse: got %b expected 1", frame_done); end
    step(1);
    vec_cnt++; if (frame_done !== 1'b0) begin miss_cnt++; $display("[TB] FAIL good_done_width: got %b expected 0", frame_done); end
    step(3);
    vec_cnt++; if (done_seen - d0 != 1) begin miss_cnt++; $display("[TB] FAIL good_done_count: got %0d expected 1", done_seen - d0); end
    vec_cnt++; if (err_seen - e0 != 0) begin miss_cnt++; $display("[TB] FAIL good_err_count: got %0d expected 0", err_seen - e0); end
    vec_cnt++; if (cap_seen - c0 != W * H) begin miss_cnt++; $display("[TB] FAIL good_capture_cycles: got %0d expected %0d", cap_seen - c0, W * H); end
    vec_cnt++; if (ready_buf !== 1'b0) begin miss_cnt++; $display("[TB] FAIL good_ready_buf: got %b expected 0", ready_buf); end
    vec_cnt++; if (ready_valid !== 1'b1) begin miss_cnt++; $display("[TB] FAIL good_ready_valid: got %b expected 1", ready_valid); end
    vec_cnt++; if (wr_buf !== 1'b1) begin miss_cnt++; $display("[TB] FAIL good_wr_buf: got %b expected 1", wr_buf); end
    vec_cnt++; if (line_cnt !== LCW'(H)) begin miss_cnt++; $display("[TB] FAIL good_line_cnt: got %0d expected %0d", line_cnt, H); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL good_busy: got %b expected 0", busy); end
    pulse_release();
    vec_cnt++; if (ready_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL good_release: got %b expected 0", ready_valid); end
  endtask

  task automatic test_bad_line();
    int d0, e0;
    do_reset();
    d0 = done_seen; e0 = err_seen;
    pulse_start();
    send_frame(2, W - 1);
    vec_cnt++; if (frame_err !== 1'b1) begin miss_cnt++; $display("[TB] FAIL bad_err_pulse: got %b expected 1", frame_err); end
    step(3);
    vec_cnt++; if (err_seen - e0 != 1) begin miss_cnt++; $display("[TB] FAIL bad_err_count: got %0d expected 1", err_seen - e0); end
    vec_cnt++; if (done_seen - d0 != 0) begin miss_cnt++; $display("[TB] FAIL bad_done_count: got %0d expected 0", done_seen - d0); end
    vec_cnt++; if (wr_buf !== 1'b0) begin miss_cnt++; $display("[TB] FAIL bad_wr_buf: got %b expected 0", wr_buf); end
    vec_cnt++; if (ready_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL bad_ready_valid: got %b expected 0", ready_valid); end
    vec_cnt++; if (line_cnt !== LCW'(H)) begin miss_cnt++; $display("[TB] FAIL bad_line_cnt: got %0d expected %0d", line_cnt, H); end
  endtask

  task automatic test_continuous_drop();
    int d0;
    do_reset();
    d0 = done_seen;
    continuous = 1'b1;
    pulse_start();
    send_frame(-1, 0);
    step(3);
    vec_cnt++; if ({ready_valid, ready_buf, wr_buf} !== 3'b101) begin miss_cnt++; $display("[TB] FAIL cont_first: got valid/buf/wr %b expected 101", {ready_valid, ready_buf, wr_buf}); end
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("[TB] FAIL cont_rearmed: got %b expected 1", busy); end
    send_frame(-1, 0);
    step(3);
    vec_cnt++; if (dropped_cnt !== DW'(1)) begin miss_cnt++; $display("[TB] FAIL cont_dropped: got %0d expected 1", dropped_cnt); end
    vec_cnt++; if (wr_buf !== 1'b1) begin miss_cnt++; $display("[TB] FAIL cont_drop_wr_buf: got %b expected 1", wr_buf); end
    vec_cnt++; if (done_seen - d0 != 1) begin miss_cnt++; $display("[TB] FAIL cont_drop_done_count: got %0d expected 1", done_seen - d0); end
    pulse_release();
    vec_cnt++; if (ready_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL cont_release: got %b expected 0", ready_valid); end
    send_frame(-1, 0);
    step(3);
    vec_cnt++; if ({ready_valid, ready_buf, wr_buf} !== 3'b110) begin miss_cnt++; $display("[TB] FAIL cont_third: got valid/buf/wr %b expected 110", {ready_valid, ready_buf, wr_buf}); end
    vec_cnt++; if (done_seen - d0 != 2) begin miss_cnt++; $display("[TB] FAIL cont_done_count: got %0d expected 2", done_seen - d0); end
    continuous = 1'b0;
    pulse_stop();
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL cont_stop_in_arm: got %b expected 0", busy); end
  endtask

  task automatic test_mid_frame_arm();
    int d0, e0, c0;
    do_reset();
    d0 = done_seen; e0 = err_seen; c0 = cap_seen;
    frame_open();
    send_line(W);
    pulse_start();
    for (int l = 1; l < H; l++) begin
      send_line(W);
    end
    VSYNC = 1'b1;
    step(5);
    vec_cnt++; if (cap_seen - c0 != 0) begin miss_cnt++; $display("[TB] FAIL arm_partial_capture: got %0d expected 0", cap_seen - c0); end
    vec_cnt++; if ((done_seen - d0) + (err_seen - e0) != 0) begin miss_cnt++; $display("[TB] FAIL arm_partial_pulses: got %0d expected 0", (done_seen - d0) + (err_seen - e0)); end
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("[TB] FAIL arm_waiting: got %b expected 1", busy); end
    send_frame(-1, 0);
    step(3);
    vec_cnt++; if (done_seen - d0 != 1) begin miss_cnt++; $display("[TB] FAIL arm_full_done: got %0d expected 1", done_seen - d0); end
    vec_cnt++; if (cap_seen - c0 != W * H) begin miss_cnt++; $display("[TB] FAIL arm_full_capture: got %0d expected %0d", cap_seen - c0, W * H); end
  endtask

  task automatic test_stop();
    int d0, c0;
    do_reset();
    d0 = done_seen;
    continuous = 1'b1;
    pulse_start();
    frame_open();
    send_line(W);
    HREF = 1'b1;
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(W - 4);
    HREF = 1'b0;
    step(3);
    send_line(W);
    send_line(W);
    frame_close();
    step(3);
    vec_cnt++; if (done_seen - d0 != 1) begin miss_cnt++; $display("[TB] FAIL stop_done_count: got %0d expected 1", done_seen - d0); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL stop_busy: got %b expected 0", busy); end
    c0 = cap_seen;
    send_frame(-1, 0);
    step(3);
    vec_cnt++; if (cap_seen - c0 != 0) begin miss_cnt++; $display("[TB] FAIL stop_no_capture: got %0d expected 0", cap_seen - c0); end
    vec_cnt++; if (done_seen - d0 != 1) begin miss_cnt++; $display("[TB] FAIL stop_no_more_done: got %0d expected 1", done_seen - d0); end
    continuous = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    #1;
    test_reset();
    test_good_frame();
    test_bad_line();
    test_continuous_drop();
    test_mid_frame_arm();
    test_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
